key8_onehot_scan: RTL and testbench
===================================

KEY8_ONEHOT_SCAN -- requirements
Module: key8_onehot_scan

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250000, meaning clk cycles per debounce sample tick (5 ms at 50 MHz); legal range 2..2^18.
REQ-002 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port key_n  input  8  raw push-buttons, active-low, asynchronous to clk.
REQ-005 SHALL have port key_onehot  output  8  one-hot code of the most recently pressed key; drives the 8-to-3 encoder x input.
REQ-006 SHALL have port key_valid  output  1  one-cycle pulse when key_onehot is loaded with a new press.
REQ-007 SHALL have port key_state  output  8  debounced key levels, active-high (1 = held).

Function
REQ-008 SHALL pass each key_n bit through a 2-flop synchronizer; the raw input reaches the second flop 2 cycles later.
REQ-009 SHALL run an 18-bit tick counter 0..TICK_DIV-1, wrapping to 0, and assert internal tick for the one cycle the counter equals TICK_DIV-1.
REQ-010 SHALL, on each tick, shift each synchronized key bit into a per-key 3-bit history; no shift on non-tick cycles.
REQ-011 SHALL update a key's debounced level on that tick edge only if the three history bits (including the new sample) are all equal; otherwise hold.
REQ-012 SHALL detect a press as a debounced level transition released->held, evaluated in the cycle after the debounced update.
REQ-013 SHALL, on a press, register key_valid=1 for exactly one cycle and load key_onehot with the pressed key's bit, both at the same edge; press to key_valid latency is one cycle after the debounced update.
REQ-014 SHALL, when multiple keys register presses on the same cycle, load only the lowest-index key; other simultaneous presses are discarded, not queued.
REQ-015 SHALL hold key_onehot between presses; release events and held keys produce no key_valid and no auto-repeat.
REQ-016 SHALL guarantee key_onehot is always 8'h00 or exactly one-hot.
REQ-017 SHALL drive key_state as the inverse of the debounced active-low levels, registered.
REQ-018 SHALL reject any bounce shorter than 3 consecutive equal tick samples.

Reset
REQ-019 SHALL, with rst=1 at a clk edge, set synchronizers, histories and debounced levels to released (all 1s), tick counter to 0, key_onehot=8'h00, key_valid=0, key_state=8'h00.
REQ-020 SHALL, when reset asserts mid-press, produce no key_valid for that key after release of rst until it is released and pressed again through full debounce... except that a key still held after reset SHALL register as a new press once debounced (3 ticks).
REQ-021 SHALL not require rst deassertion to be aligned to tick.

Structure
REQ-022 SHALL place KEY_NUM=8 and the TICK_DIV default in the shared constants package/include used by the encoder practice designs.
REQ-023 SHALL implement per-key synchronizer+history+debounce as sub-module key_debounce_bit, instantiated 8 times, sharing one tick from the parent.
REQ-024 SHALL keep priority selection and output registers in the parent; target 120-250 RTL lines total.

Verification (TICK_DIV=4)
REQ-025 Reset: rst high 3 cycles, key_n=8'hFF -> key_onehot=8'h00, key_valid=0, key_state=8'h00.
REQ-026 Clean press: key_n[3]=0 held 20 cycles -> exactly one key_valid pulse, key_onehot=8'b00001000, key_state[3]=1; hold 100 more cycles -> no further pulse.
REQ-027 Bounce: key_n[6] toggles low for 6 cycles then high -> no key_valid, key_onehot unchanged, key_state[6]=0.
REQ-028 Simultaneous: key_n[2], key_n[5] drop on same cycle -> one pulse, key_onehot=8'b00000100; key 5 never reported until re-pressed.
REQ-029 Sequential: press key0, release, press key7 -> two pulses, key_onehot 8'h01 then 8'h80; downstream encoder output 0 then 7.
REQ-030 Reset mid-press: key_n[4]=0 debounced, rst pulse 1 cycle while held -> outputs cleared, then one key_valid with key_onehot=8'b00010000 after 3 ticks.

Source files
------------

// File: rtl/key8_onehot_scan_pkg.sv
// Shared constants for the key-scan / 8-to-3 encoder practice designs.
// Also holds the lowest-index one-hot selection helper used by the scanner.
package key8_onehot_scan_pkg;

  localparam int KEY_NUM          = 8;
  localparam int TICK_DIV_DEFAULT = 250000;
  localparam int CNT_W            = 18;

  // Isolates the lowest set bit: v & -v in two's complement.
  function automatic logic [KEY_NUM-1:0] lowest_onehot(input logic [KEY_NUM-1:0] v);
    return v & (~v + KEY_NUM'(1));
  endfunction

endpackage

// File: rtl/key8_onehot_scan_if.sv
// Key-scan bus: raw active-low buttons in, one-hot code / pulse / levels out.
interface key8_onehot_scan_if;
  import key8_onehot_scan_pkg::*;

  logic [KEY_NUM-1:0] key_n;
  logic [KEY_NUM-1:0] key_onehot;
  logic               key_valid;
  logic [KEY_NUM-1:0] key_state;

  modport master (output key_n, input key_onehot, key_valid, key_state);
  modport slave  (input key_n, output key_onehot, key_valid, key_state);
endinterface

// File: rtl/key8_onehot_scan_debounce.sv
// One key: 2-flop synchronizer, tick-sampled history and debounced level.
// o_press is high for the single cycle after the level falls to held.
module key_debounce_bit (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  logic [1:0] r_sync;
  logic [1:0] r_hist;
  logic       r_level;
  logic       r_level_d;
  logic [2:0] w_window;

  // Two stored samples plus the incoming one form the 3-sample window.
  assign w_window = {r_hist, r_sync[1]};

  // Synchronizer, sample history and debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_hist    <= 2'b11;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], i_key_n};
      r_level_d <= r_level;
      if (i_tick) begin
        r_hist <= w_window[1:0];
        if ((&w_window) || (~|w_window)) begin
          r_level <= r_sync[1];
        end else begin
          r_level <= r_level;
        end
      end else begin
        r_hist  <= r_hist;
        r_level <= r_level;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_level_d & ~r_level;

endmodule

// File: rtl/key8_onehot_scan.sv
// Eight debounced push-buttons scanned into a one-hot code of the latest press.
// Simultaneous presses resolve to the lowest key index; the rest are dropped.
module key8_onehot_scan
  import key8_onehot_scan_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  key8_onehot_scan_if.slave     bus
);

  logic [CNT_W-1:0]   r_cnt;
  logic               w_tick;
  logic [KEY_NUM-1:0] w_level;
  logic [KEY_NUM-1:0] w_press;
  logic [KEY_NUM-1:0] w_sel;
  logic [KEY_NUM-1:0] r_key_onehot;
  logic               r_key_valid;
  logic [KEY_NUM-1:0] r_key_state;

  assign w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign w_sel  = lowest_onehot(w_press);

  // Debounce sample tick counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_tick) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_debounce_bit u_deb (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (w_tick),
      .i_key_n (bus.key_n[g]),
      .o_level (w_level[g]),
      .o_press (w_press[g])
    );
  end

  // Output registers: press code, pulse and debounced levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_onehot <= {KEY_NUM{1'b0}};
      r_key_valid  <= 1'b0;
      r_key_state  <= {KEY_NUM{1'b0}};
    end else begin
      r_key_state <= ~w_level;
      r_key_valid <= |w_press;
      if (|w_press) begin
        r_key_onehot <= w_sel;
      end else begin
        r_key_onehot <= r_key_onehot;
      end
    end
  end

  assign bus.key_onehot = r_key_onehot;
  assign bus.key_valid  = r_key_valid;
  assign bus.key_state  = r_key_state;

endmodule

// File: tb/tb_key8_onehot_scan.sv
// Bench for key8_onehot_scan with TICK_DIV=4: directed segment table,
// a hand-written latency sequence and random key activity against a model.
module tb_key8_onehot_scan;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  key8_onehot_scan_if bus ();

  key8_onehot_scan #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int seg_pulses = 0;

  // Reference model state: inputs awaiting synchronization, last three
  // tick samples, debounced level now and one cycle ago, expected outputs.
  logic [7:0] m_dq[$];
  logic [7:0] m_samp[$];
  logic [7:0] m_level, m_level_d, m_onehot, m_state;
  logic       m_valid;
  int         m_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_dq      = '{8'hFF, 8'hFF};
    m_samp    = '{8'hFF, 8'hFF, 8'hFF};
    m_level   = 8'hFF;
    m_level_d = 8'hFF;
    m_onehot  = 8'h00;
    m_valid   = 1'b0;
    m_state   = 8'h00;
    m_cyc     = 0;
  endtask

  task automatic model_edge(input logic r, input logic [7:0] kn);
    logic [7:0] press;
    logic [7:0] s;
    bit found;
    if (r) begin
      model_reset();
    end else begin
      press   = m_level_d & ~m_level;
      m_valid = (press != 8'h00);
      found   = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (press[i] && !found) begin
          m_onehot = 8'h01 << i;
          found    = 1'b1;
        end
      end
      m_state   = ~m_level;
      m_level_d = m_level;
      s = m_dq.pop_front();
      m_dq.push_back(kn);
      if ((m_cyc % TD) == TD - 1) begin
        m_samp.push_back(s);
        void'(m_samp.pop_front());
        for (int i = 0; i < 8; i++) begin
          if (m_samp[0][i] == m_samp[1][i] && m_samp[1][i] == m_samp[2][i])
            m_level[i] = m_samp[2][i];
        end
      end
      m_cyc++;
    end
  endtask

  // One clock: drive, let the edge pass, advance the model, compare at +1.
  task automatic cycle(input logic r, input logic [7:0] kn);
    rst = r;
    bus.key_n = kn;
    @(posedge clk);
    model_edge(r, kn);
    #1;
    check("key_valid",  {31'd0, bus.key_valid}, {31'd0, m_valid});
    check("key_onehot", {24'd0, bus.key_onehot}, {24'd0, m_onehot});
    check("key_state",  {24'd0, bus.key_state}, {24'd0, m_state});
    check("onehot_form", {31'd0, (bus.key_onehot == 8'h00) || $onehot(bus.key_onehot)}, 32'd1);
    if (bus.key_valid === 1'b1) seg_pulses++;
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] key_n;
    int         cycles;
    int         pulses;
    logic [7:0] onehot;
    logic [7:0] state;
  } seg_t;

  seg_t tbl[17];
  logic [7:0] kn;

  initial begin
    tbl[0]  = '{1'b1, 8'hFF,   3, 0, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 8'hF7,  20, 1, 8'h08, 8'h08};
    tbl[2]  = '{1'b0, 8'hF7, 100, 0, 8'h08, 8'h08};
    tbl[3]  = '{1'b0, 8'hFF,  20, 0, 8'h08, 8'h00};
    tbl[4]  = '{1'b0, 8'hBF,   6, 0, 8'h08, 8'h00};
    tbl[5]  = '{1'b0, 8'hFF,  20, 0, 8'h08, 8'h00};
    tbl[6]  = '{1'b0, 8'hDB,  20, 1, 8'h04, 8'h24};
    tbl[7]  = '{1'b0, 8'hDB,  40, 0, 8'h04, 8'h24};
    tbl[8]  = '{1'b0, 8'hFF,  20, 0, 8'h04, 8'h00};
    tbl[9]  = '{1'b0, 8'hFE,  20, 1, 8'h01, 8'h01};
    tbl[10] = '{1'b0, 8'hFF,  20, 0, 8'h01, 8'h00};
    tbl[11] = '{1'b0, 8'h7F,  20, 1, 8'h80, 8'h80};
    tbl[12] = '{1'b0, 8'hFF,  20, 0, 8'h80, 8'h00};
    tbl[13] = '{1'b0, 8'hEF,  20, 1, 8'h10, 8'h10};
    tbl[14] = '{1'b1, 8'hEF,   1, 0, 8'h00, 8'h00};
    tbl[15] = '{1'b0, 8'hEF,  20, 1, 8'h10, 8'h10};
    tbl[16] = '{1'b0, 8'hFF,  20, 0, 8'h10, 8'h00};

    model_reset();
    bus.key_n = 8'hFF;

    for (int t = 0; t < 17; t++) begin
      seg_pulses = 0;
      for (int c = 0; c < tbl[t].cycles; c++) cycle(tbl[t].rst, tbl[t].key_n);
      check($sformatf("seg%0d_pulses", t), seg_pulses, tbl[t].pulses);
      check($sformatf("seg%0d_onehot", t), {24'd0, bus.key_onehot}, {24'd0, tbl[t].onehot});
      check($sformatf("seg%0d_state", t), {24'd0, bus.key_state}, {24'd0, tbl[t].state});
    end

    // Press latency from reset: samples at edges 4, 8, 12; pulse after edge 13.
    cycle(1'b1, 8'hFF);
    cycle(1'b1, 8'hFF);
    for (int i = 1; i <= 14; i++) begin
      cycle(1'b0, 8'hFD);
      if (i == 13) begin
        check("latency_pulse", {31'd0, bus.key_valid}, 32'd1);
        check("latency_code", {24'd0, bus.key_onehot}, 32'h02);
      end else begin
        check($sformatf("latency_quiet%0d", i), {31'd0, bus.key_valid}, 32'd0);
      end
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'hFF);

    // Random key activity with bounces, multi-key overlaps and rare resets.
    kn = 8'hFF;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) kn[$urandom_range(0, 7)] ^= 1'b1;
      cycle(($urandom_range(0, 599) == 0), kn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
